// File: rtl/btle_rx_scan_ctrl.sv
// BLE advertising-channel scan controller: hops 37/38/39, resets the rx core
// between channels, supervises packet reception and hands reports downstream.
module btle_rx_scan_ctrl #(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int LEN_UNIQUE_BIT_SEQUENCE  = 32,
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int WINDOW_BIT_WIDTH         = 20
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                stop,
    input  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]  access_address,
    input  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_init,
    input  logic [WINDOW_BIT_WIDTH-1:0]         scan_window,
    input  logic [WINDOW_BIT_WIDTH-1:0]         pkt_timeout,
    input  logic                                hit_flag,
    input  logic                                decode_end,
    input  logic                                crc_ok,
    input  logic [6:0]                          payload_length,
    output logic                                core_rst,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    output logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]  unique_bit_sequence,
    output logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
    output logic                                rpt_valid,
    input  logic                                rpt_ready,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] rpt_channel,
    output logic                                rpt_crc_ok,
    output logic [6:0]                          rpt_length,
    output logic                                rpt_timeout,
    output logic                                busy,
    output logic [7:0]                          good_pkt_count
);

    localparam int CW = CHANNEL_NUMBER_BIT_WIDTH;
    localparam int AW = LEN_UNIQUE_BIT_SEQUENCE;
    localparam int KW = CRC_STATE_BIT_WIDTH;
    localparam int WW = WINDOW_BIT_WIDTH;
    localparam logic [CW-1:0] CH37 = CW'(37);
    localparam logic [CW-1:0] CH38 = CW'(38);
    localparam logic [CW-1:0] CH39 = CW'(39);

    typedef enum logic [2:0] {IDLE, RESET_CORE, LISTEN, RECEIVE, REPORT, HOP} state_t;

    state_t          state_q, state_d;
    logic            rc_cnt_q, rc_cnt_d;
    logic [WW-1:0]   win_cnt_q, win_cnt_d, to_cnt_q, to_cnt_d;
    logic [WW-1:0]   sw_q, sw_d, pt_q, pt_d;
    logic [AW-1:0]   aa_q, aa_d;
    logic [KW-1:0]   crc_q, crc_d;
    logic [CW-1:0]   chan_q, chan_d, rpt_chan_q, rpt_chan_d;
    logic            core_rst_q, core_rst_d, busy_q, busy_d;
    logic            rpt_valid_q, rpt_valid_d, rpt_crc_ok_q, rpt_crc_ok_d;
    logic            rpt_timeout_q, rpt_timeout_d, stop_pending_q, stop_pending_d;
    logic [6:0]      rpt_len_q, rpt_len_d;
    logic [7:0]      good_cnt_q, good_cnt_d;

    logic [WW-1:0]   win_last, to_last;
    logic            start_ok, handshake, win_done, to_done;

    // A zero window or timeout behaves as a single cycle.
    assign win_last  = (sw_q == '0) ? '0 : sw_q - WW'(1);
    assign to_last   = (pt_q == '0) ? '0 : pt_q - WW'(1);
    assign win_done  = (win_cnt_q == win_last);
    assign to_done   = (to_cnt_q == to_last);
    assign start_ok  = start && !stop;
    assign handshake = (state_q == REPORT) && rpt_valid_q && rpt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rc_cnt_q       <= 1'b0;
            win_cnt_q      <= '0;
            to_cnt_q       <= '0;
            sw_q           <= '0;
            pt_q           <= '0;
            aa_q           <= '0;
            crc_q          <= '0;
            chan_q         <= CH37;
            rpt_chan_q     <= '0;
            core_rst_q     <= 1'b1;
            busy_q         <= 1'b0;
            rpt_valid_q    <= 1'b0;
            rpt_crc_ok_q   <= 1'b0;
            rpt_timeout_q  <= 1'b0;
            rpt_len_q      <= '0;
            stop_pending_q <= 1'b0;
            good_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            rc_cnt_q       <= rc_cnt_d;
            win_cnt_q      <= win_cnt_d;
            to_cnt_q       <= to_cnt_d;
            sw_q           <= sw_d;
            pt_q           <= pt_d;
            aa_q           <= aa_d;
            crc_q          <= crc_d;
            chan_q         <= chan_d;
            rpt_chan_q     <= rpt_chan_d;
            core_rst_q     <= core_rst_d;
            busy_q         <= busy_d;
            rpt_valid_q    <= rpt_valid_d;
            rpt_crc_ok_q   <= rpt_crc_ok_d;
            rpt_timeout_q  <= rpt_timeout_d;
            rpt_len_q      <= rpt_len_d;
            stop_pending_q <= stop_pending_d;
            good_cnt_q     <= good_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (start_ok) state_d = RESET_CORE;
            RESET_CORE: if (stop) state_d = IDLE;
                        else if (rc_cnt_q) state_d = LISTEN;
            LISTEN:     if (stop) state_d = IDLE;
                        else if (hit_flag) state_d = RECEIVE;
                        else if (win_done) state_d = HOP;
            RECEIVE:    if (decode_end || to_done) state_d = REPORT;
            REPORT:     if (handshake) state_d = HOP;
            HOP:        state_d = stop_pending_q ? IDLE : RESET_CORE;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the upcoming state.
    always_comb begin
        sw_d           = sw_q;
        pt_d           = pt_q;
        aa_d           = aa_q;
        crc_d          = crc_q;
        chan_d         = chan_q;
        rpt_chan_d     = rpt_chan_q;
        rpt_crc_ok_d   = rpt_crc_ok_q;
        rpt_timeout_d  = rpt_timeout_q;
        rpt_len_d      = rpt_len_q;
        good_cnt_d     = good_cnt_q;
        stop_pending_d = stop_pending_q;
        rc_cnt_d       = (state_q == RESET_CORE) && !rc_cnt_q;
        win_cnt_d      = (state_q == LISTEN)  ? win_cnt_q + WW'(1) : '0;
        to_cnt_d       = (state_q == RECEIVE) ? to_cnt_q + WW'(1)  : '0;
        core_rst_d     = (state_d == IDLE) || (state_d == RESET_CORE);
        busy_d         = (state_d != IDLE);
        rpt_valid_d    = (state_d == REPORT);

        if (state_q == IDLE && start_ok) begin
            aa_d   = access_address;
            crc_d  = crc_init;
            sw_d   = scan_window;
            pt_d   = pkt_timeout;
            chan_d = CH37;
        end

        if (state_q == HOP) begin
            unique case (chan_q)
                CH37:    chan_d = CH38;
                CH38:    chan_d = CH39;
                default: chan_d = CH37;
            endcase
        end

        if (state_q == RECEIVE) begin
            if (decode_end) begin
                rpt_chan_d    = chan_q;
                rpt_crc_ok_d  = crc_ok;
                rpt_len_d     = payload_length;
                rpt_timeout_d = 1'b0;
            end else if (to_done) begin
                rpt_chan_d    = chan_q;
                rpt_crc_ok_d  = 1'b0;
                rpt_len_d     = '0;
                rpt_timeout_d = 1'b1;
            end
        end

        if (handshake && rpt_crc_ok_q) good_cnt_d = good_cnt_q + 8'd1;

        if (state_d == IDLE) stop_pending_d = 1'b0;
        else if (stop && (state_q == RECEIVE || state_q == REPORT || state_q == HOP))
            stop_pending_d = 1'b1;
    end

    assign core_rst            = core_rst_q;
    assign channel_number      = chan_q;
    assign unique_bit_sequence = aa_q;
    assign crc_state_init_bit  = crc_q;
    assign rpt_valid           = rpt_valid_q;
    assign rpt_channel         = rpt_chan_q;
    assign rpt_crc_ok          = rpt_crc_ok_q;
    assign rpt_length          = rpt_len_q;
    assign rpt_timeout         = rpt_timeout_q;
    assign busy                = busy_q;
    assign good_pkt_count      = good_cnt_q;

endmodule

// File: tb/tb_btle_rx_scan_ctrl.sv
// Directed bench for btle_rx_scan_ctrl: channel hopping, reception, timeout,
// stop handling and async reset, with expected reports held in a scoreboard queue.
module tb_btle_rx_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [31:0] access_address = '0;
    logic [23:0] crc_init = '0;
    logic [19:0] scan_window = '0, pkt_timeout = '0;
    logic        hit_flag = 1'b0, decode_end = 1'b0, crc_ok = 1'b0;
    logic [6:0]  payload_length = '0;
    logic        rpt_ready = 1'b0;
    logic        core_rst, rpt_valid, rpt_crc_ok, rpt_timeout, busy;
    logic [5:0]  channel_number, rpt_channel;
    logic [31:0] unique_bit_sequence;
    logic [23:0] crc_state_init_bit;
    logic [6:0]  rpt_length;
    logic [7:0]  good_pkt_count;

    typedef struct {
        logic [5:0] ch;
        logic       crcOk;
        logic [6:0] len;
        logic       tmo;
    } rpt_t;

    rpt_t expQ[$];
    int   compareCount = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    btle_rx_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .access_address(access_address), .crc_init(crc_init),
        .scan_window(scan_window), .pkt_timeout(pkt_timeout),
        .hit_flag(hit_flag), .decode_end(decode_end), .crc_ok(crc_ok),
        .payload_length(payload_length), .core_rst(core_rst),
        .channel_number(channel_number), .unique_bit_sequence(unique_bit_sequence),
        .crc_state_init_bit(crc_state_init_bit), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .rpt_channel(rpt_channel), .rpt_crc_ok(rpt_crc_ok),
        .rpt_length(rpt_length), .rpt_timeout(rpt_timeout), .busy(busy),
        .good_pkt_count(good_pkt_count)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkReport(input bit doPop);
        rpt_t e;
        if (expQ.size() == 0) begin
            compareCount++;
            failCount++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = doPop ? expQ.pop_front() : expQ[0];
        checkOutput("rpt_valid", rpt_valid, 1);
        checkOutput("rpt_channel", rpt_channel, e.ch);
        checkOutput("rpt_crc_ok", rpt_crc_ok, e.crcOk);
        checkOutput("rpt_length", rpt_length, e.len);
        checkOutput("rpt_timeout", rpt_timeout, e.tmo);
    endtask

    // Starts at the first RESET_CORE sample of a channel, ends at the next one.
    task automatic scanChannel(input logic [5:0] ch, input int win);
        checkOutput("rc1_core_rst", core_rst, 1);
        checkOutput("rc_channel", channel_number, ch);
        tick(1);
        checkOutput("rc2_core_rst", core_rst, 1);
        tick(1);
        for (int i = 0; i < win; i++) begin
            checkOutput("listen_core_rst", core_rst, 0);
            checkOutput("listen_channel", channel_number, ch);
            tick(1);
        end
        checkOutput("hop_core_rst", core_rst, 0);
        checkOutput("hop_busy", busy, 1);
        tick(1);
    endtask

    task automatic applyStimulus(input logic s, input logic p);
        start = s;
        stop  = p;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        tick(2);
        $display("[TB] reset values");
        checkOutput("reset_core_rst", core_rst, 1);
        checkOutput("reset_channel", channel_number, 37);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rpt_valid", rpt_valid, 0);
        checkOutput("reset_good", good_pkt_count, 0);
        checkOutput("reset_ubs", unique_bit_sequence, 0);
        rst_n = 1'b1;

        $display("[TB] hopping with no hit");
        access_address = 32'h8E89BED6;
        crc_init       = 24'h555555;
        scan_window    = 20'd10;
        pkt_timeout    = 20'd100;
        applyStimulus(1'b1, 1'b0);
        checkOutput("start_busy", busy, 1);
        checkOutput("ubs_latched", unique_bit_sequence, 32'h8E89BED6);
        checkOutput("crc_latched", crc_state_init_bit, 24'h555555);
        scanChannel(6'd37, 10);
        scanChannel(6'd38, 10);
        scanChannel(6'd39, 10);
        checkOutput("wrap_channel", channel_number, 37);
        applyStimulus(1'b0, 1'b1);
        checkOutput("stop_rc_busy", busy, 0);
        checkOutput("stop_rc_core_rst", core_rst, 1);

        $display("[TB] packet on channel 38 with backpressure");
        applyStimulus(1'b1, 1'b0);
        tick(15);
        checkOutput("listen38_channel", channel_number, 38);
        checkOutput("listen38_core_rst", core_rst, 0);
        hit_flag = 1'b1;
        tick(1);
        hit_flag = 1'b0;
        tick(49);
        checkOutput("receive_no_valid", rpt_valid, 0);
        decode_end = 1'b1; crc_ok = 1'b1; payload_length = 7'd12;
        expQ.push_back('{ch: 6'd38, crcOk: 1'b1, len: 7'd12, tmo: 1'b0});
        tick(1);
        decode_end = 1'b0; crc_ok = 1'b0; payload_length = 7'd0;
        for (int i = 0; i < 5; i++) begin
            checkReport(1'b0);
            tick(1);
        end
        rpt_ready = 1'b1;
        checkReport(1'b1);
        tick(1);
        rpt_ready = 1'b0;
        checkOutput("hs_valid_fall", rpt_valid, 0);
        checkOutput("good_after_pkt", good_pkt_count, 1);
        tick(1);
        checkOutput("next_channel_39", channel_number, 39);
        tick(2);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        checkOutput("stop_listen_busy", busy, 0);
        checkOutput("stop_listen_core_rst", core_rst, 1);

        $display("[TB] packet timeout");
        applyStimulus(1'b1, 1'b0);
        tick(2);
        hit_flag = 1'b1;
        tick(1);
        hit_flag = 1'b0;
        expQ.push_back('{ch: 6'd37, crcOk: 1'b0, len: 7'd0, tmo: 1'b1});
        tick(99);
        checkOutput("tmo_99_no_valid", rpt_valid, 0);
        tick(1);
        checkReport(1'b0);
        rpt_ready = 1'b1;
        checkReport(1'b1);
        tick(1);
        rpt_ready = 1'b0;
        checkOutput("tmo_good_unchanged", good_pkt_count, 1);

        $display("[TB] stop during RECEIVE");
        tick(3);
        hit_flag = 1'b1;
        tick(1);
        hit_flag = 1'b0;
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        decode_end = 1'b1; crc_ok = 1'b0; payload_length = 7'd5;
        expQ.push_back('{ch: 6'd38, crcOk: 1'b0, len: 7'd5, tmo: 1'b0});
        tick(1);
        decode_end = 1'b0; payload_length = 7'd0;
        checkOutput("pending_busy", busy, 1);
        rpt_ready = 1'b1;
        checkReport(1'b1);
        tick(1);
        rpt_ready = 1'b0;
        checkOutput("pending_hop_busy", busy, 1);
        tick(1);
        checkOutput("pending_idle_busy", busy, 0);
        checkOutput("pending_idle_core_rst", core_rst, 1);

        $display("[TB] start+stop, start while busy, hit at window expiry");
        applyStimulus(1'b1, 1'b1);
        tick(1);
        checkOutput("startstop_busy", busy, 0);
        checkOutput("startstop_core_rst", core_rst, 1);
        access_address = 32'hA1A1A1A1;
        applyStimulus(1'b1, 1'b0);
        tick(1);
        access_address = 32'hB2B2B2B2;
        scan_window    = 20'd3;
        applyStimulus(1'b1, 1'b0);
        checkOutput("busy_start_ubs", unique_bit_sequence, 32'hA1A1A1A1);
        tick(9);
        hit_flag = 1'b1;
        tick(1);
        hit_flag = 1'b0;
        tick(2);
        checkOutput("hit_expiry_channel", channel_number, 37);
        checkOutput("hit_expiry_core_rst", core_rst, 0);
        checkOutput("hit_expiry_no_valid", rpt_valid, 0);
        decode_end = 1'b1; crc_ok = 1'b1; payload_length = 7'd20;
        expQ.push_back('{ch: 6'd37, crcOk: 1'b1, len: 7'd20, tmo: 1'b0});
        tick(1);
        decode_end = 1'b0; crc_ok = 1'b0; payload_length = 7'd0;
        checkReport(1'b0);

        $display("[TB] async reset in REPORT");
        rst_n = 1'b0;
        #1;
        checkOutput("arst_core_rst", core_rst, 1);
        checkOutput("arst_channel", channel_number, 37);
        checkOutput("arst_ubs", unique_bit_sequence, 0);
        checkOutput("arst_crc", crc_state_init_bit, 0);
        checkOutput("arst_rpt_valid", rpt_valid, 0);
        checkOutput("arst_rpt_channel", rpt_channel, 0);
        checkOutput("arst_rpt_crc_ok", rpt_crc_ok, 0);
        checkOutput("arst_rpt_length", rpt_length, 0);
        checkOutput("arst_rpt_timeout", rpt_timeout, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_good", good_pkt_count, 0);
        expQ.delete();
        tick(1);
        rst_n = 1'b1;
        access_address = 32'hC3C3C3C3;
        scan_window    = 20'd4;
        tick(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("fresh_ubs", unique_bit_sequence, 32'hC3C3C3C3);
        tick(2);
        hit_flag = 1'b1;
        tick(1);
        hit_flag = 1'b0;
        decode_end = 1'b1; crc_ok = 1'b1; payload_length = 7'd7;
        expQ.push_back('{ch: 6'd37, crcOk: 1'b1, len: 7'd7, tmo: 1'b0});
        tick(1);
        decode_end = 1'b0; crc_ok = 1'b0; payload_length = 7'd0;
        rpt_ready = 1'b1;
        checkReport(1'b1);
        tick(1);
        rpt_ready = 1'b0;
        checkOutput("fresh_valid_fall", rpt_valid, 0);
        checkOutput("fresh_good", good_pkt_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
